// File: rtl/trs80_pkg.sv
// trs80_pkg: .CMD record codes, header length and the cmd_saver state encoding
package trs80_pkg;

    localparam logic [7:0] CMD_REC_LOAD = 8'h01;
    localparam logic [7:0] CMD_REC_XFER = 8'h02;
    localparam logic [7:0] CMD_REC_NAME = 8'h05;
    localparam int         HDR_LEN      = 8;

    typedef enum logic [3:0] {
        IDLE, REQ, HDR, B_TYPE, B_LEN, B_ALO, B_AHI, B_RD, B_DATA,
        X_TYPE, X_LEN, X_LO, X_HI, FIN
    } state_t;

endpackage

// File: rtl/cmd_saver.sv
// cmd_saver: streams a RAM region out as a TRS-80 .CMD file; define CMD_SAVER_HEADER_EN to prepend the NAME header record
module cmd_saver
    import trs80_pkg::*;
#(
    parameter logic [47:0] NAME = "TRS80 "
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] end_addr,
    input  logic [15:0] exec_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [23:0] file_size,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);

    state_t      st_q, st_d;
    logic [15:0] cur_q, cur_d, exec_q, exec_d;
    logic [16:0] rem_q, rem_d;
    logic [8:0]  blk_q, blk_d;
    logic [2:0]  h_q, h_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, req_q, req_d, ov_q, ov_d;
    logic [23:0] fsz_q, fsz_d;
    logic [7:0]  od_q, od_d;

    logic [16:0] span;
    logic [17:0] nblk;
    logic [23:0] size;
    logic [8:0]  k;
    logic        ld;

    assign span = {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;
    assign nblk = ({1'b0, span} + 18'd255) >> 8;
`ifdef CMD_SAVER_HEADER_EN
    assign size = {4'd0, nblk, 2'b00} + {7'd0, span} + 24'd4 + 24'(HDR_LEN);
`else
    assign size = {4'd0, nblk, 2'b00} + {7'd0, span} + 24'd4;
`endif
    assign k  = rem_q > 17'd256 ? 9'd256 : rem_q[8:0];
    // a new byte may enter the output register when it is empty or being accepted, and only while the bus is held
    assign ld = bus_ack && (!ov_q || out_ready);

    always_comb begin
        st_d   = st_q;
        cur_d  = cur_q;
        exec_d = exec_q;
        rem_d  = rem_q;
        blk_d  = blk_q;
        h_d    = h_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d  = err_q;
        req_d  = req_q;
        fsz_d  = fsz_q;
        od_d   = od_q;
        ov_d   = ov_q && !out_ready;
        case (st_q)
            IDLE: if (start) begin
                cur_d  = start_addr;
                exec_d = exec_addr;
                rem_d  = span;
                fsz_d  = size;
                err_d  = start_addr > end_addr;
                done_d = start_addr > end_addr;
                busy_d = start_addr <= end_addr;
                req_d  = start_addr <= end_addr;
                st_d   = start_addr > end_addr ? IDLE : REQ;
            end
`ifdef CMD_SAVER_HEADER_EN
            REQ: begin
                h_d  = 3'd0;
                st_d = bus_ack ? HDR : REQ;
            end
`else
            REQ: begin
                h_d  = 3'd0;
                st_d = bus_ack ? B_TYPE : REQ;
            end
`endif
            HDR: if (ld) begin
                od_d = h_q == 3'd0 ? CMD_REC_NAME : h_q == 3'd1 ? 8'h06 : NAME[8*(7-int'(h_q)) +: 8];
                ov_d = 1'b1;
                h_d  = h_q + 3'd1;
                st_d = h_q == 3'(HDR_LEN - 1) ? B_TYPE : HDR;
            end
            B_TYPE: if (ld) begin
                od_d  = CMD_REC_LOAD;
                ov_d  = 1'b1;
                blk_d = k;
                st_d  = B_LEN;
            end
            B_LEN: if (ld) begin
                od_d = 8'(blk_q + 9'd2);
                ov_d = 1'b1;
                st_d = B_ALO;
            end
            B_ALO: if (ld) begin
                od_d = cur_q[7:0];
                ov_d = 1'b1;
                st_d = B_AHI;
            end
            B_AHI: if (ld) begin
                od_d = cur_q[15:8];
                ov_d = 1'b1;
                st_d = B_RD;
            end
            B_RD: if (bus_ack && !ov_q) st_d = B_DATA;
            // read data is valid for this cycle only, so capture regardless of bus_ack
            B_DATA: begin
                od_d  = mem_data;
                ov_d  = 1'b1;
                cur_d = cur_q + 16'd1;
                rem_d = rem_q - 17'd1;
                blk_d = blk_q - 9'd1;
                st_d  = blk_q != 9'd1 ? B_RD : rem_q == 17'd1 ? X_TYPE : B_TYPE;
            end
            X_TYPE: if (ld) begin
                od_d = CMD_REC_XFER;
                ov_d = 1'b1;
                st_d = X_LEN;
            end
            X_LEN: if (ld) begin
                od_d = 8'h02;
                ov_d = 1'b1;
                st_d = X_LO;
            end
            X_LO: if (ld) begin
                od_d = exec_q[7:0];
                ov_d = 1'b1;
                st_d = X_HI;
            end
            X_HI: if (ld) begin
                od_d = exec_q[15:8];
                ov_d = 1'b1;
                st_d = FIN;
            end
            FIN: if (ov_q && out_ready) begin
                done_d = 1'b1;
                busy_d = 1'b0;
                req_d  = 1'b0;
                st_d   = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q   <= IDLE;
            cur_q  <= '0;
            exec_q <= '0;
            rem_q  <= '0;
            blk_q  <= '0;
            h_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            req_q  <= 1'b0;
            fsz_q  <= '0;
            od_q   <= '0;
            ov_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            cur_q  <= cur_d;
            exec_q <= exec_d;
            rem_q  <= rem_d;
            blk_q  <= blk_d;
            h_q    <= h_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
            req_q  <= req_d;
            fsz_q  <= fsz_d;
            od_q   <= od_d;
            ov_q   <= ov_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = err_q;
    assign file_size = fsz_q;
    assign bus_req   = req_q;
    assign mem_rd    = (st_q == B_RD) && bus_ack && !ov_q;
    assign mem_addr  = cur_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;

endmodule

// File: tb/tb_cmd_saver.sv
// tb_cmd_saver: randomized checks of cmd_saver against a queue-based .CMD file model
module tb_cmd_saver;

    typedef byte unsigned bq_t[$];

`ifdef CMD_SAVER_HEADER_EN
    localparam int HL = 8;
`else
    localparam int HL = 0;
`endif

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [15:0] start_addr = '0, end_addr = '0, exec_addr = '0;
    logic        busy, done, error, bus_req, mem_rd, out_valid;
    logic [23:0] file_size;
    logic        bus_ack = 1'b0, out_ready = 1'b1;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data = '0, out_data;

    cmd_saver dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .exec_addr(exec_addr), .busy(busy), .done(done),
        .error(error), .file_size(file_size), .bus_req(bus_req), .bus_ack(bus_ack),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clock = ~clock;

    logic [7:0]  mem [0:65535];
    int          n_chk = 0, n_pass = 0;
    int          done_cnt = 0, req_seen = 0, ov_seen = 0, ack_viol = 0, stab_viol = 0;
    bit          ack_en = 1'b1, rdy_rand = 1'b0, pv = 1'b0;
    logic [7:0]  pd = '0;
    bq_t         got, exp;
    logic [23:0] fsz_seen;
    logic        busy_seen;

    // synchronous RAM: data valid exactly one cycle after the strobe, garbage otherwise
    always @(posedge clock) begin
        mem_data <= mem_rd ? mem[mem_addr] : 8'($urandom);
        bus_ack  <= bus_req && ack_en;
    end

    always @(posedge clock) begin
        #2;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clock) begin
        if (reset) pv = 1'b0;
        else begin
            if (pv && (!out_valid || out_data !== pd)) stab_viol++;
            if (mem_rd && !bus_ack) ack_viol++;
            if (bus_req) req_seen++;
            if (out_valid) ov_seen++;
            if (done) done_cnt++;
            if (out_valid && out_ready) got.push_back(out_data);
            pv = out_valid && !out_ready;
            pd = out_data;
        end
    end

    function automatic bq_t model(input logic [15:0] s, input logic [15:0] e, input logic [15:0] x);
        bq_t q;
        string nm = "TRS80 ";
        int rem = int'(e) - int'(s) + 1;
        logic [15:0] a = s;
        if (HL > 0) begin
            q.push_back(8'h05);
            q.push_back(8'h06);
            for (int i = 0; i < 6; i++) q.push_back(nm[i]);
        end
        while (rem > 0) begin
            int kk = rem > 256 ? 256 : rem;
            q.push_back(8'h01);
            q.push_back(8'((kk + 2) % 256));
            q.push_back(a[7:0]);
            q.push_back(a[15:8]);
            for (int i = 0; i < kk; i++) begin
                q.push_back(mem[a]);
                a++;
            end
            rem -= kk;
        end
        q.push_back(8'h02);
        q.push_back(8'h02);
        q.push_back(x[7:0]);
        q.push_back(x[15:8]);
        return q;
    endfunction

    function automatic int first_diff(bq_t a, bq_t b);
        int n = a.size() < b.size() ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return a.size() == b.size() ? -1 : n;
    endfunction

    task automatic do_save(input logic [15:0] s, input logic [15:0] e, input logic [15:0] x, output bit to);
        got.delete();
        done_cnt = 0; req_seen = 0; ov_seen = 0; ack_viol = 0; stab_viol = 0;
        @(negedge clock);
        start = 1'b1; start_addr = s; end_addr = e; exec_addr = x;
        @(negedge clock);
        start = 1'b0;
        fsz_seen = file_size;
        busy_seen = busy;
        to = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if (done_cnt > 0) begin
                to = 1'b0;
                break;
            end
            @(negedge clock);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_chk++;
        if ({busy, done, error, bus_req, mem_rd, out_valid, out_data, mem_addr, file_size} !== '0)
            $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%b %h %h %h want all zero",
                     busy, done, error, bus_req, mem_rd, out_valid, out_data, mem_addr, file_size);
        else n_pass++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        bit to;
        int d;
        bq_t lit;
        mem[16'h4000] = 8'hAA; mem[16'h4001] = 8'hBB; mem[16'h4002] = 8'hCC;
        if (HL > 0) lit = '{8'h05, 8'h06, 8'h54, 8'h52, 8'h53, 8'h38, 8'h30, 8'h20};
        lit = {lit, 8'h01, 8'h05, 8'h00, 8'h40, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h40};
        rdy_rand = 1'b0;
        do_save(16'h4000, 16'h4002, 16'h4000, to);
        n_chk++; if (to) $display("FAIL basic_timeout done never seen"); else n_pass++;
        n_chk++; if (fsz_seen !== 24'(11 + HL)) $display("FAIL basic_size got=%0d want=%0d", fsz_seen, 11 + HL); else n_pass++;
        n_chk++; if (busy_seen !== 1'b1) $display("FAIL basic_busy_rise got=%b want=1", busy_seen); else n_pass++;
        d = first_diff(got, lit);
        n_chk++; if (d != -1) $display("FAIL basic_stream byte %0d got=%h want=%h (len %0d/%0d)", d, got[d], lit[d], got.size(), lit.size()); else n_pass++;
        n_chk++; if (done_cnt != 1) $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); else n_pass++;
        n_chk++; if ({busy, bus_req, error} !== 3'b000) $display("FAIL basic_idle busy/bus_req/error got=%b want=000", {busy, bus_req, error}); else n_pass++;
    endtask

    task automatic test_blocks();
        bit to;
        int d;
        rdy_rand = 1'b0;
        do_save(16'h5200, 16'h52FF, 16'h5234, to);
        exp = model(16'h5200, 16'h52FF, 16'h5234);
        n_chk++; if (to || fsz_seen !== 24'(264 + HL)) $display("FAIL blk256_size got=%0d want=%0d timeout=%b", fsz_seen, 264 + HL, to); else n_pass++;
        n_chk++;
        if (got.size() < HL + 4 || {got[HL], got[HL+1], got[HL+2], got[HL+3]} !== 32'h01020052)
            $display("FAIL blk256_head got=%h %h %h %h want=01 02 00 52", got[HL], got[HL+1], got[HL+2], got[HL+3]);
        else n_pass++;
        d = first_diff(got, exp);
        n_chk++; if (d != -1) $display("FAIL blk256_stream byte %0d got=%h want=%h", d, got[d], exp[d]); else n_pass++;
        rdy_rand = 1'b1;
        do_save(16'h5200, 16'h5300, 16'h1234, to);
        exp = model(16'h5200, 16'h5300, 16'h1234);
        n_chk++; if (to || fsz_seen !== 24'(269 + HL)) $display("FAIL blk257_size got=%0d want=%0d timeout=%b", fsz_seen, 269 + HL, to); else n_pass++;
        n_chk++;
        if (got.size() < HL + 264 || {got[HL+260], got[HL+261], got[HL+262], got[HL+263]} !== 32'h01030053)
            $display("FAIL blk257_second got=%h %h %h %h want=01 03 00 53", got[HL+260], got[HL+261], got[HL+262], got[HL+263]);
        else n_pass++;
        d = first_diff(got, exp);
        n_chk++; if (d != -1) $display("FAIL blk257_stream byte %0d got=%h want=%h", d, got[d], exp[d]); else n_pass++;
    endtask

    task automatic test_edges();
        bit to;
        int d;
        rdy_rand = 1'b0;
        do_save(16'hFFFF, 16'hFFFF, 16'h0000, to);
        exp = model(16'hFFFF, 16'hFFFF, 16'h0000);
        n_chk++; if (to || fsz_seen !== 24'(9 + HL)) $display("FAIL one_byte_size got=%0d want=%0d timeout=%b", fsz_seen, 9 + HL, to); else n_pass++;
        d = first_diff(got, exp);
        n_chk++; if (d != -1) $display("FAIL one_byte_stream byte %0d got=%h want=%h", d, got[d], exp[d]); else n_pass++;
        do_save(16'hFF00, 16'hFFFF, 16'hFF10, to);
        exp = model(16'hFF00, 16'hFFFF, 16'hFF10);
        d = first_diff(got, exp);
        n_chk++; if (to || d != -1) $display("FAIL top_page_stream byte %0d got=%h want=%h timeout=%b", d, got[d], exp[d], to); else n_pass++;
    endtask

    task automatic test_error();
        bit to;
        do_save(16'h6000, 16'h5FFF, 16'h6000, to);
        n_chk++; if (to || done_cnt != 1) $display("FAIL err_done got=%0d pulses want=1 timeout=%b", done_cnt, to); else n_pass++;
        n_chk++; if (error !== 1'b1) $display("FAIL err_sticky got=%b want=1", error); else n_pass++;
        n_chk++; if (req_seen != 0 || ov_seen != 0 || busy_seen !== 1'b0) $display("FAIL err_quiet bus_req=%0d out_valid=%0d busy=%b want 0/0/0", req_seen, ov_seen, busy_seen); else n_pass++;
    endtask

    task automatic test_stall();
        bit to, wto;
        int d;
        rdy_rand = 1'b0;
        ack_en = 1'b0;
        fork
            do_save(16'h7000, 16'h703F, 16'h7001, to);
            begin
                repeat (10) @(negedge clock);
                ack_en = 1'b1;
                wto = 1'b1;
                for (int i = 0; i < 2000; i++) begin
                    if (got.size() >= HL + 8) begin
                        wto = 1'b0;
                        break;
                    end
                    @(negedge clock);
                end
                ack_en = 1'b0;
                start = 1'b1; start_addr = 16'h1000; end_addr = 16'h1001; exec_addr = 16'h1000;
                @(negedge clock);
                start = 1'b0;
                repeat (4) @(negedge clock);
                ack_en = 1'b1;
            end
        join
        exp = model(16'h7000, 16'h703F, 16'h7001);
        n_chk++; if (to || wto) $display("FAIL stall_timeout save=%b data=%b want 0/0", to, wto); else n_pass++;
        n_chk++; if (ack_viol != 0) $display("FAIL stall_mem_rd_without_ack got=%0d want=0", ack_viol); else n_pass++;
        d = first_diff(got, exp);
        n_chk++; if (d != -1) $display("FAIL stall_stream byte %0d got=%h want=%h", d, got[d], exp[d]); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit to;
        int d;
        logic [15:0] s = 16'($urandom_range(0, 65535 - 300));
        rdy_rand = 1'b1;
        do_save(s, s + 16'd299, s ^ 16'h5A5A, to);
        exp = model(s, s + 16'd299, s ^ 16'h5A5A);
        n_chk++; if (to || fsz_seen !== 24'(exp.size())) $display("FAIL bp_size got=%0d want=%0d timeout=%b", fsz_seen, exp.size(), to); else n_pass++;
        n_chk++; if (stab_viol != 0) $display("FAIL bp_hold out_data changed while stalled %0d times want=0", stab_viol); else n_pass++;
        d = first_diff(got, exp);
        n_chk++; if (d != -1) $display("FAIL bp_stream byte %0d got=%h want=%h", d, got[d], exp[d]); else n_pass++;
    endtask

    task automatic test_random();
        bit to;
        int d, len;
        logic [15:0] s, x;
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 700);
            s = 16'($urandom_range(0, 65536 - len));
            x = 16'($urandom);
            rdy_rand = r[0];
            do_save(s, 16'(int'(s) + len - 1), x, to);
            exp = model(s, 16'(int'(s) + len - 1), x);
            d = first_diff(got, exp);
            n_chk++;
            if (to || d != -1 || fsz_seen !== 24'(exp.size()) || stab_viol != 0)
                $display("FAIL rand%0d len=%0d byte %0d got=%h want=%h size=%0d want=%0d stall_viol=%0d", r, len, d, got[d], exp[d], fsz_seen, exp.size(), stab_viol);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit to, wto;
        int d;
        rdy_rand = 1'b0;
        got.delete();
        @(negedge clock);
        start = 1'b1; start_addr = 16'h8000; end_addr = 16'h80FF; exec_addr = 16'h8000;
        @(negedge clock);
        start = 1'b0;
        wto = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (got.size() >= HL + 6) begin
                wto = 1'b0;
                break;
            end
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (wto || {busy, done, error, bus_req, mem_rd, out_valid, out_data, mem_addr, file_size} !== '0)
            $display("FAIL midreset_outputs got=%b/%b/%b/%b/%b/%b %h %h %h want all zero timeout=%b",
                     busy, done, error, bus_req, mem_rd, out_valid, out_data, mem_addr, file_size, wto);
        else n_pass++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        do_save(16'h8000, 16'h80FF, 16'h8000, to);
        exp = model(16'h8000, 16'h80FF, 16'h8000);
        n_chk++; if (to || got.size() == 0 || got[0] !== (HL > 0 ? 8'h05 : 8'h01)) $display("FAIL midreset_first got=%h want=%h timeout=%b", got[0], HL > 0 ? 8'h05 : 8'h01, to); else n_pass++;
        d = first_diff(got, exp);
        n_chk++; if (d != -1) $display("FAIL midreset_stream byte %0d got=%h want=%h", d, got[d], exp[d]); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_blocks();
        test_edges();
        test_error();
        test_stall();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cmd_saver.md
# cmd_saver

Serialises a region of TRS-80 main memory into a TRS-80 `.CMD` file byte stream for upload to the HPS, the reverse of the `.CMD` download loader. It sits between the `trs80` memory port and the HPS upload path. It requests the CPU bus, reads RAM sequentially, frames the data as load-block records, and appends a transfer-address record. One save request produces one complete file.

## Interface
Parameters:
- `NAME`, default `"TRS80 "`: 6-byte ASCII module name for the optional header record.

Ports:
- `clock`  in  1  system clock (42 MHz)
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a save when idle
- `start_addr`  in  16  first RAM byte to save
- `end_addr`  in  16  last RAM byte to save (inclusive)
- `exec_addr`  in  16  transfer address written in the final record
- `busy`  out  1  save in progress
- `done`  out  1  one-cycle pulse at end of save
- `error`  out  1  sticky until next `start`; set when `start_addr > end_addr`
- `file_size`  out  24  total byte count of the file; valid from the cycle after `start`
- `bus_req`  out  1  request the CPU be halted and the bus released
- `bus_ack`  in  1  bus granted
- `mem_rd`  out  1  read strobe
- `mem_addr`  out  16  RAM address
- `mem_data`  in  8  read data, valid exactly 1 cycle after `mem_rd`
- `out_valid`  out  1  `out_data` holds a file byte
- `out_ready`  in  1  consumer accepts the byte when both `out_valid` and `out_ready` are high
- `out_data`  out  8  file byte

## Operation
- States: IDLE, REQ, HDR, B_TYPE, B_LEN, B_ALO, B_AHI, B_RD, B_DATA, X_TYPE, X_LEN, X_LO, X_HI, FIN.
- IDLE + `start`:
  - Latch the three addresses and clear `error`.
  - If `start_addr > end_addr`: set `error`, pulse `done`, stay IDLE. `bus_req` never rises.
  - Otherwise go to REQ.
- REQ: assert `bus_req`, hold it through FIN, and wait for `bus_ack`. Then go to HDR if the header is configured, else B_TYPE.
- Load block (one per ≤256 data bytes, from the current address):
  - Emit `01`.
  - Emit `L = (k+2) mod 256`, where k is the block's data count (1..256).
  - Emit the address low byte, then the high byte.
  - Emit k data bytes. Each byte: B_RD pulses `mem_rd` with `mem_addr` = current address, captures `mem_data` on the next cycle, then B_DATA presents the byte.
  - k = min(256, remaining).
- Transfer record: emit `02 02 lo(exec_addr) hi(exec_addr)`. Then FIN: drop `bus_req`, pulse `done`, return to IDLE.
- Width rules:
  - remaining = `end_addr - start_addr + 1` as 17 bits (max 65536).
  - Current address increments as 16 bits. Wrap at FFFF is reached only on the final byte and is not used afterwards.
  - nblocks = ceil(remaining/256).
  - `file_size` = 4·nblocks + remaining + 4, plus the header length if configured.
- `start` while busy is ignored.
- `bus_ack` falling mid-save: the FSM freezes in its current state with outputs held, and resumes when `bus_ack` returns.

## Timing
- Reset values: `busy`, `done`, `error`, `bus_req`, `mem_rd`, `out_valid` = 0; `out_data`, `mem_addr` = 0; `file_size` = 0. Reset mid-save abandons the file and releases the bus immediately.
- `busy` rises the cycle after an accepted `start` and falls with the `done` pulse.
- `out_valid`/`out_data` are registered. Once `out_valid` is asserted, `out_data` holds until accepted. A framing byte may be offered the cycle after the previous accept.
- Data byte throughput: one byte per 3 cycles with `out_ready` held high (accept, read, capture).
- `mem_rd` is a single-cycle pulse and is issued only while `bus_ack` = 1.
- `done` is asserted the cycle after the final byte (`hi(exec_addr)`) is accepted.

## Configuration
- `CMD_SAVER_HEADER_EN` defined: a header record `05 06` followed by the 6 `NAME` bytes is emitted first, and `file_size` includes these 8 bytes.
- Not defined: no header record; the HDR state and the `NAME` parameter are unused.

## Structure
- Shared package `trs80_pkg`:
  - record type constants: `CMD_REC_LOAD`=8'h01, `CMD_REC_XFER`=8'h02, `CMD_REC_NAME`=8'h05
  - the FSM state enum
  - the header length constant
- No sub-module. The size calculator is a single combinational expression registered on `start`.

## Test plan
- Bytes 0x4000..0x4002 = AA BB CC, start=4000, end=4002, exec=4000, `out_ready` high → stream `01 05 00 40 AA BB CC 02 02 00 40`, `file_size`=11, one `done` pulse.
- Region of 256 bytes, start=5200, end=52FF → first record `01 02 00 52` + 256 data bytes, `file_size`=264. Region of 257 bytes → second record `01 03 00 53` + 1 byte.
- start=6000, end=5FFF → `error`=1, `done` pulse, `bus_req` never asserted, no `out_valid`.
- `bus_ack` delayed 10 cycles, then deasserted mid-data for 5 cycles → no `mem_rd` while `bus_ack`=0, stream identical to the unstalled run.
- Random `out_ready` backpressure (50%) over a 300-byte region → byte-exact match with the reference model, `out_data` stable while stalled.
- Reset asserted mid-B_DATA → all outputs 0 within the reset cycle. A following `start` produces a complete, correct file; with `CMD_SAVER_HEADER_EN` the stream begins `05 06 54 52 53 38 30 20`.
